// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack handshake carrying a bundled data word
// into another clock domain, with a completed-transfer counter.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HIGH = 2'd1,
    REQ_LOW  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   stage1;
  logic   ack_s;
  logic   accept;
  logic   drop;
  logic   finish;

  // ack comes from the destination clock domain; nothing but ack_s may see it.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stage1 <= 1'b0;
      ack_s  <= 1'b0;
    end else begin
      stage1 <= ack_i;
      ack_s  <= stage1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = REQ_HIGH;
      REQ_HIGH: if (ack_s)  state_next = REQ_LOW;
      REQ_LOW:  if (!ack_s) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE) && !ack_s;
    accept  = valid_i && ready_o;
    drop    = (state == REQ_HIGH) && ack_s;
    finish  = (state == REQ_LOW) && !ack_s;
  end

  // req_o and data_o come straight from flops so the destination never sees a
  // decode glitch; data_o holds until the next accepted word.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      req_o   <= 1'b0;
      data_o  <= '0;
      done_o  <= 1'b0;
      count_o <= '0;
    end else begin
      done_o <= finish;
      if (accept) begin
        req_o  <= 1'b1;
        data_o <= data_i;
      end else if (drop) begin
        req_o <= 1'b0;
      end
      if (finish) begin
        count_o <= count_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Randomised and directed bench for cdc_handshake_tx, checked every cycle
// against a transaction-level model of the handshake.
module tb_cdc_handshake_tx;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          ack_i;
  logic          done_o;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;

  // Model: ack seen by the logic is ack_i delayed by two source edges; a transfer
  // is "waiting for ack" (phase 1) then "waiting for ack release" (phase 2).
  logic          m_stage1;
  logic          m_ack_s;
  logic          m_req;
  logic          m_done;
  logic [DW-1:0] m_data;
  int            m_phase;
  int            m_completed;
  int            m_accepts;
  int            done_pulses = 0;
  int            dut_pulses  = 0;
  logic [DW-1:0] obs_q[$];

  bit resp_en   = 0;
  int resp_wait = 0;

  always #5 clock_i = ~clock_i;

  cdc_handshake_tx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .req_o  (req_o),
    .data_o (data_o),
    .ack_i  (ack_i),
    .done_o (done_o),
    .count_o(count_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic expReady();
    return (m_phase == 0) && !m_ack_s;
  endfunction

  task automatic modelReset();
    m_stage1    = 1'b0;
    m_ack_s     = 1'b0;
    m_req       = 1'b0;
    m_done      = 1'b0;
    m_data      = '0;
    m_phase     = 0;
    m_completed = 0;
  endtask

  // Destination side: follows req with a random delay of 0..4 cycles each way.
  task automatic applyResponder();
    if (m_req != ack_i) begin
      if (resp_wait == 0) begin
        ack_i     = m_req;
        resp_wait = $urandom_range(0, 4);
      end else begin
        resp_wait--;
      end
    end
  endtask

  // Check at the falling edge, predict the next rising edge, return at posedge+1.
  task automatic stepCycle();
    logic          n_stage1, n_ack_s, n_req, n_done;
    logic [DW-1:0] n_data;
    int            n_phase;
    @(negedge clock_i);
    checkOutput("ready", ready_o, expReady());
    checkOutput("req", req_o, m_req);
    checkOutput("data", data_o, m_data);
    checkOutput("done", done_o, m_done);
    checkOutput("count", count_o, m_completed % 256);
    if (done_o === 1'b1) begin
      dut_pulses++;
      obs_q.push_back(data_o);
    end
    n_phase = m_phase;
    n_req   = m_req;
    n_data  = m_data;
    n_done  = 1'b0;
    if (m_phase == 0 && valid_i && expReady()) begin
      n_phase = 1;
      n_req   = 1'b1;
      n_data  = data_i;
      m_accepts++;
    end else if (m_phase == 1 && m_ack_s) begin
      n_phase = 2;
      n_req   = 1'b0;
    end else if (m_phase == 2 && !m_ack_s) begin
      n_phase = 0;
      n_done  = 1'b1;
    end
    n_stage1 = ack_i;
    n_ack_s  = m_stage1;
    @(posedge clock_i);
    #1;
    m_stage1 = n_stage1;
    m_ack_s  = n_ack_s;
    m_phase  = n_phase;
    m_req    = n_req;
    m_data   = n_data;
    m_done   = n_done;
    if (n_done) begin
      m_completed++;
      done_pulses++;
    end
    if (resp_en) applyResponder();
  endtask

  // Entered and left at posedge+1 so the next check sees the reset state.
  task automatic applyReset();
    reset_i = 1'b1;
    modelReset();
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int c = 0; c < 200 && (m_phase != 0 || ack_i); c++) stepCycle();
    if (m_phase != 0 || ack_i) checkOutput(tag, 0, 1);
  endtask

  task automatic applyStimulus();
    int start;
    bit seen255;

    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    ack_i   = 1'b0;
    modelReset();
    #12;
    checkOutput("reset_req", req_o, 0);
    checkOutput("reset_count", count_o, 0);
    checkOutput("reset_ready", ready_o, 1);
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;

    // Basic transfer followed by a busy offer while req is high.
    stepCycle();
    valid_i = 1'b1;
    data_i  = 8'hA5;
    stepCycle();
    checkOutput("basic_data", data_o, 8'hA5);
    checkOutput("basic_req", req_o, 1);
    data_i = 8'h3C;
    repeat (3) stepCycle();
    checkOutput("busy_data", data_o, 8'hA5);
    checkOutput("busy_ready", ready_o, 0);
    checkOutput("busy_req", req_o, 1);
    valid_i = 1'b0;
    stepCycle();
    ack_i = 1'b1;
    repeat (2) stepCycle();
    checkOutput("req_hold_2nd_edge", req_o, 1);
    stepCycle();
    checkOutput("req_fall_3rd_edge", req_o, 0);
    repeat (3) stepCycle();
    ack_i = 1'b0;
    repeat (2) stepCycle();
    checkOutput("done_early", done_o, 0);
    stepCycle();
    checkOutput("done_3rd_edge", done_o, 1);
    checkOutput("basic_count", count_o, 1);
    stepCycle();
    checkOutput("done_one_cycle", done_o, 0);

    // Glitch on ack between edges, then a sampled ack toggle while idle.
    #1 ack_i = 1'b1;
    #2 ack_i = 1'b0;
    repeat (3) stepCycle();
    checkOutput("glitch_ready", ready_o, 1);
    ack_i = 1'b1;
    stepCycle();
    ack_i = 1'b0;
    repeat (4) stepCycle();

    // Stuck ack blocks a waiting source until two edges after release.
    ack_i = 1'b1;
    repeat (3) stepCycle();
    valid_i = 1'b1;
    data_i  = 8'h5A;
    repeat (4) stepCycle();
    checkOutput("stuck_ready", ready_o, 0);
    checkOutput("stuck_req", req_o, 0);
    ack_i = 1'b0;
    stepCycle();
    checkOutput("stuck_ready_1", ready_o, 0);
    stepCycle();
    checkOutput("stuck_ready_2", ready_o, 1);
    stepCycle();
    checkOutput("stuck_fire_req", req_o, 1);
    checkOutput("stuck_fire_data", data_o, 8'h5A);
    valid_i = 1'b0;
    resp_en = 1;
    waitIdle("timeout_stuck");
    stepCycle();
    checkOutput("stuck_count", count_o, 2);

    // Reset between edges while req is high.
    resp_en = 0;
    valid_i = 1'b1;
    data_i  = 8'hC3;
    stepCycle();
    valid_i = 1'b0;
    stepCycle();
    @(negedge clock_i);
    #2 reset_i = 1'b1;
    #1;
    checkOutput("midreset_req", req_o, 0);
    checkOutput("midreset_data", data_o, 0);
    checkOutput("midreset_count", count_o, 0);
    checkOutput("midreset_done", done_o, 0);
    modelReset();
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    stepCycle();
    checkOutput("postreset_ready", ready_o, 1);

    // Back-to-back words with valid held high.
    resp_en   = 1;
    m_accepts = 0;
    obs_q.delete();
    valid_i = 1'b1;
    data_i  = 8'h01;
    for (int c = 0; c < 200 && m_accepts < 1; c++) stepCycle();
    data_i = 8'h02;
    for (int c = 0; c < 200 && m_accepts < 2; c++) stepCycle();
    valid_i = 1'b0;
    for (int c = 0; c < 200 && m_completed < 2; c++) stepCycle();
    if (m_completed < 2) checkOutput("timeout_b2b", m_completed, 2);
    stepCycle();
    checkOutput("b2b_count", count_o, 2);
    checkOutput("b2b_words", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      checkOutput("b2b_first", obs_q[0], 8'h01);
      checkOutput("b2b_second", obs_q[1], 8'h02);
    end

    // Random traffic and random destination timing.
    for (int c = 0; c < 1500; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      data_i  = DW'($urandom);
      stepCycle();
    end
    valid_i = 1'b0;
    waitIdle("timeout_random");

    // Counter wrap after 256 transfers from reset.
    applyReset();
    start   = dut_pulses;
    seen255 = 0;
    valid_i = 1'b1;
    for (int c = 0; c < 20000 && m_completed < 256; c++) begin
      data_i = DW'($urandom);
      stepCycle();
      if (m_completed == 255 && !seen255) begin
        seen255 = 1;
        checkOutput("wrap_255", count_o, 8'hFF);
      end
    end
    if (m_completed < 256) checkOutput("timeout_wrap", m_completed, 256);
    checkOutput("wrap_zero", count_o, 0);
    valid_i = 1'b0;
    stepCycle();
    checkOutput("wrap_pulses", dut_pulses - start, 256);
    waitIdle("timeout_end");
  endtask

  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
